// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
// Optional leading-zero blank mask enabled by macro LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [BIN_W-1:0]  r_shift;
  logic [SW-1:0]     r_scratch;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_bcd;
  logic [DIGITS-1:0] r_blank;

  logic [SW-1:0]     w_adj;
  logic [SW-1:0]     w_scratch_next;
  logic [DIGITS-1:0] w_blank_next;
  logic              w_accept;
  logic              w_last;

  // All nibbles are corrected in parallel before the shift; add-3 wraps within the nibble.
  always_comb begin
    w_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      else
        w_adj[4*d +: 4] = r_scratch[4*d +: 4];
    end
  end

  assign w_scratch_next = (w_adj << 1) | SW'(r_shift[BIN_W-1]);
  assign w_accept       = start && (r_state != S_SHIFT);
  assign w_last         = (r_count == CW'(1));

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic all_zero;
    w_blank_next = '0;
    all_zero     = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero        = all_zero && (w_scratch_next[4*k +: 4] == 4'd0);
      w_blank_next[k] = all_zero;
    end
  end
`else
  assign w_blank_next = '0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_SHIFT : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_bcd     <= '0;
      r_blank   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_shift   <= bin_in;
        r_scratch <= '0;
        r_count   <= CW'(BIN_W);
      end else if (r_state == S_SHIFT) begin
        r_shift   <= r_shift << 1;
        r_scratch <= w_scratch_next;
        r_count   <= r_count - CW'(1);
        // Output only ever sees the completed conversion, never partial scratch.
        if (w_last) begin
          r_bcd   <= w_scratch_next;
          r_blank <= w_blank_next;
        end
      end
    end
  end

  assign busy    = (r_state == S_SHIFT);
  assign done    = (r_state == S_DONE);
  assign bcd_out = r_bcd;
  assign blank   = r_blank;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq (BIN_W=8, DIGITS=3)
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin_in = '0;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
  logic [2:0]  blank;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .blank   (blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [2:0]  blk;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] dec_ref(input int v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic logic [2:0] blank_exp(input logic [2:0] m);
`ifdef LEADING_ZERO_BLANK_EN
    return m;
`else
    return (m & 3'b000);
`endif
  endfunction

  // Called at the first negedge after the accepting edge; counts edges from that accept edge.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && edges < 30) begin
      @(negedge clk);
      edges++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic kick(input logic [7:0] v);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
  endtask

  initial begin
    int edges, bcnt, extra;
    logic nib_ok;

    vecs[0] = '{8'd0,   12'h000, 3'b110};
    vecs[1] = '{8'd255, 12'h255, 3'b000};
    vecs[2] = '{8'd7,   12'h007, 3'b110};
    vecs[3] = '{8'd40,  12'h040, 3'b100};
    vecs[4] = '{8'd99,  12'h099, 3'b100};
    vecs[5] = '{8'd100, 12'h100, 3'b000};
    vecs[6] = '{8'd9,   12'h009, 3'b110};
    vecs[7] = '{8'd10,  12'h010, 3'b100};
    vecs[8] = '{8'd128, 12'h128, 3'b000};
    vecs[9] = '{8'd199, 12'h199, 3'b000};

    repeat (2) @(negedge clk);
    check("reset_busy",  busy, 0);
    check("reset_done",  done, 0);
    check("reset_bcd",   bcd_out, 0);
    check("reset_blank", blank, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_done", done, 0);

    for (int i = 0; i < 10; i++) begin
      kick(vecs[i].bin);
      wait_done(edges, bcnt);
      check($sformatf("lat_%0d", vecs[i].bin), edges, 9);
      check($sformatf("busy_cycles_%0d", vecs[i].bin), bcnt, 8);
      check($sformatf("bcd_%0d", vecs[i].bin), bcd_out, vecs[i].bcd);
      check($sformatf("blank_%0d", vecs[i].bin), blank, blank_exp(vecs[i].blk));
      @(negedge clk);
      check($sformatf("done_pulse_%0d", vecs[i].bin), done, 0);
    end

    // Back-to-back sweep: the next start is presented while done is high.
    kick(8'd0);
    for (int v = 0; v < 256; v++) begin
      wait_done(edges, bcnt);
      check($sformatf("sweep_lat_%0d", v), edges, 9);
      check($sformatf("sweep_bcd_%0d", v), bcd_out, dec_ref(v));
      nib_ok = (bcd_out[3:0] <= 4'd9) && (bcd_out[7:4] <= 4'd9) && (bcd_out[11:8] <= 4'd9);
      check($sformatf("sweep_nibble_%0d", v), nib_ok, 1);
      if (v < 255) kick(8'(v + 1));
      else @(negedge clk);
    end
    check("sweep_idle", done, 0);

    // Start during SHIFT is ignored.
    kick(8'd99);
    @(negedge clk);
    @(negedge clk);
    check("busy_mid", busy, 1);
    kick(8'd7);
    edges = 4;
    while (!done && edges < 30) begin
      @(negedge clk);
      edges++;
    end
    check("ignore_lat", edges, 9);
    check("ignore_bcd", bcd_out, 12'h099);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ignore_single_done", extra, 0);
    check("ignore_hold", bcd_out, 12'h099);

    // Asynchronous reset mid-conversion.
    kick(8'd123);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  busy, 0);
    check("arst_done",  done, 0);
    check("arst_bcd",   bcd_out, 0);
    check("arst_blank", blank, 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("arst_no_done", extra, 0);
    check("arst_bcd_hold", bcd_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
